// File: rtl/hd44780_lcd_controller.sv
// -----------------------------------------------------------------------------
// hd44780_lcd_controller
//   Wishbone-style slave that writes one byte (plus register-select) per
//   accepted strobe to an HD44780 character LCD wired in 4-bit mode. Each byte
//   goes out as high nybble then low nybble, each in a fixed-length slot with
//   an E pulse. The controller then waits out the command execution time
//   before accepting the next byte. A free-running counter drives a heartbeat
//   LED.
//
//   Optional feature macro: H4_POWERON_INIT_EN
//     When defined, the controller runs the 4-bit power-on init sequence after
//     reset release (busy held high throughout).
//
// Ports
//   CLK_I        in   system clock, rising edge
//   RST_I        in   asynchronous active-low reset
//   STB_I        in   request strobe (accepted only while busy is low)
//   i_rs         in   register select for the byte (0 command, 1 data)
//   i_lcd_data   in   byte to send
//   busy         out  byte or init in progress; strobes ignored while high
//   alive_led    out  heartbeat, MSB of a free-running counter
//   o_rs         out  LCD RS pin
//   o_lcd_data   out  LCD D7..D4 pins
//   o_e          out  LCD E pin
// -----------------------------------------------------------------------------
module hd44780_lcd_controller #(
    parameter int T_AS       = 1,
    parameter int T_PWEH     = 6,
    parameter int T_AH       = 1,
    parameter int T_EPAD     = 7,
    parameter int DLY_CMD    = 636,
`ifdef H4_POWERON_INIT_EN
    parameter int DLY_100MS  = 1200000,
    parameter int DLY_4P1MS  = 49200,
    parameter int DLY_3MS    = 36000,
    parameter int DLY_100US  = 1200,
`endif
    parameter int BLINK_BITS = 23
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic       i_rs,
    input  logic [7:0] i_lcd_data,
    output logic       busy,
    output logic       alive_led,
    output logic       o_rs,
    output logic [3:0] o_lcd_data,
    output logic       o_e
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NS = T_AS + T_PWEH + T_AH + T_EPAD + 1;
`ifdef H4_POWERON_INIT_EN
    localparam int MAX_DLY = max2(max2(max2(NS, DLY_CMD), max2(DLY_100MS, DLY_4P1MS)),
                                  max2(DLY_3MS, DLY_100US));
`else
    localparam int MAX_DLY = max2(NS, DLY_CMD);
`endif
    localparam int CNT_W = $clog2(MAX_DLY + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(NS - 1);
    localparam logic [CNT_W-1:0] E_ON      = CNT_W'(T_AS);
    localparam logic [CNT_W-1:0] E_OFF     = CNT_W'(T_AS + T_PWEH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HI       = 3'd1,
        S_LO       = 3'd2,
        S_WAIT     = 3'd3,
        S_PWR      = 3'd4,
        S_INIT_NYB = 3'd5
    } state_t;

`ifdef H4_POWERON_INIT_EN
    // Steps 0..3 are single nybbles, 4..8 full bytes; STEP_DONE marks normal operation.
    localparam logic [3:0] STEP_DONE = 4'd9;

    function automatic logic [7:0] init_item(input logic [3:0] step);
        case (step)
            4'd0, 4'd1, 4'd2: init_item = 8'h03;
            4'd3:             init_item = 8'h02;
            4'd4:             init_item = 8'h28;
            4'd5:             init_item = 8'h08;
            4'd6:             init_item = 8'h01;
            4'd7:             init_item = 8'h06;
            4'd8:             init_item = 8'h0C;
            default:          init_item = 8'h00;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_nyb_wait(input logic [3:0] step);
        case (step)
            4'd0:    init_nyb_wait = CNT_W'(DLY_4P1MS);
            default: init_nyb_wait = CNT_W'(DLY_100US);
        endcase
    endfunction

    logic [3:0] r_step, w_step_nxt;
    logic [7:0] w_item;
`endif

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]     r_dly, w_dly_nxt;
    logic [3:0]           r_lo, w_lo_nxt;
    logic [3:0]           r_data, w_data_nxt;
    logic                 r_rs, w_rs_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_e, w_e_nxt;
    logic [BLINK_BITS-1:0] r_blink;

    // Next-state, timer and pin values for the byte/init sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_dly_nxt   = r_dly;
        w_lo_nxt    = r_lo;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_busy_nxt  = r_busy;
`ifdef H4_POWERON_INIT_EN
        w_step_nxt  = r_step;
        w_item      = init_item(r_step + 4'd1);
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = CNT_W'(0);
                if (STB_I) begin
                    w_state_nxt = S_HI;
                    w_data_nxt  = i_lcd_data[7:4];
                    w_lo_nxt    = i_lcd_data[3:0];
                    w_rs_nxt    = i_rs;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_HI: begin
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = CNT_W'(0);
                    w_data_nxt  = r_lo;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_LO: begin
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(0);
`ifdef H4_POWERON_INIT_EN
                    // Clear-display (init step 6) needs the long execution delay.
                    w_dly_nxt   = (r_step == 4'd6) ? CNT_W'(DLY_3MS) : CNT_W'(DLY_CMD);
`else
                    w_dly_nxt   = CNT_W'(DLY_CMD);
`endif
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (r_cnt == (r_dly - CNT_W'(1))) begin
                    w_cnt_nxt = CNT_W'(0);
`ifdef H4_POWERON_INIT_EN
                    if (r_step < 4'd8) begin
                        w_step_nxt = r_step + 4'd1;
                        w_rs_nxt   = 1'b0;
                        if (r_step < 4'd3) begin
                            w_state_nxt = S_INIT_NYB;
                            w_data_nxt  = w_item[3:0];
                        end else begin
                            w_state_nxt = S_HI;
                            w_data_nxt  = w_item[7:4];
                            w_lo_nxt    = w_item[3:0];
                        end
                    end else begin
                        w_step_nxt  = STEP_DONE;
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef H4_POWERON_INIT_EN
            S_PWR: begin
                if (r_cnt == (r_dly - CNT_W'(1))) begin
                    w_state_nxt = S_INIT_NYB;
                    w_cnt_nxt   = CNT_W'(0);
                    w_data_nxt  = 4'h3;
                    w_rs_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_INIT_NYB: begin
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(0);
                    w_dly_nxt   = init_nyb_wait(r_step);
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_W'(0);
                w_busy_nxt  = 1'b0;
            end
        endcase
        // E is registered, so decide it from the slot position of the next cycle.
        w_e_nxt = ((w_state_nxt == S_HI) || (w_state_nxt == S_LO) || (w_state_nxt == S_INIT_NYB))
                  && (w_cnt_nxt >= E_ON) && (w_cnt_nxt < E_OFF);
    end

    // Sequencer state, timer and registered LCD pins.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
`ifdef H4_POWERON_INIT_EN
            r_state <= S_PWR;
            r_busy  <= 1'b1;
            r_dly   <= CNT_W'(DLY_100MS);
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_dly   <= CNT_W'(0);
`endif
            r_cnt   <= CNT_W'(0);
            r_lo    <= 4'h0;
            r_data  <= 4'h0;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_dly   <= w_dly_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lo    <= w_lo_nxt;
            r_data  <= w_data_nxt;
            r_rs    <= w_rs_nxt;
            r_e     <= w_e_nxt;
        end
    end

`ifdef H4_POWERON_INIT_EN
    // Init step index.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_step <= 4'd0;
        end else begin
            r_step <= w_step_nxt;
        end
    end
`endif

    // Free-running heartbeat counter.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_blink <= BLINK_BITS'(0);
        end else begin
            r_blink <= r_blink + BLINK_BITS'(1);
        end
    end

    assign busy       = r_busy;
    assign alive_led  = r_blink[BLINK_BITS-1];
    assign o_rs       = r_rs;
    assign o_lcd_data = r_data;
    assign o_e        = r_e;

endmodule

// File: tb/tb_hd44780_lcd_controller.sv
// -----------------------------------------------------------------------------
// tb_hd44780_lcd_controller
//   Directed self-checking bench for hd44780_lcd_controller. Expected pin
//   values per cycle are derived from the slot timing (E high on slot cycles
//   1..6, 16-cycle slots) and the command delay. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_hd44780_lcd_controller;

`ifdef H4_POWERON_INIT_EN
    localparam int TB_DLY_CMD = 10;
    localparam logic RST_BUSY = 1'b1;
`else
    localparam int TB_DLY_CMD = 20;
    localparam logic RST_BUSY = 1'b0;
`endif
    localparam int NS = 16;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic       i_rs = 1'b0;
    logic [7:0] i_lcd_data = 8'h00;
    logic       busy;
    logic       alive_led;
    logic       o_rs;
    logic [3:0] o_lcd_data;
    logic       o_e;

    int checks = 0;
    int failures = 0;
    logic [31:0] edge_cnt;

    hd44780_lcd_controller #(
        .T_AS      (1),
        .T_PWEH    (6),
        .T_AH      (1),
        .T_EPAD    (7),
        .DLY_CMD   (TB_DLY_CMD),
`ifdef H4_POWERON_INIT_EN
        .DLY_100MS (10),
        .DLY_4P1MS (10),
        .DLY_3MS   (10),
        .DLY_100US (10),
`endif
        .BLINK_BITS(4)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .STB_I     (STB_I),
        .i_rs      (i_rs),
        .i_lcd_data(i_lcd_data),
        .busy      (busy),
        .alive_led (alive_led),
        .o_rs      (o_rs),
        .o_lcd_data(o_lcd_data),
        .o_e       (o_e)
    );

    always #5 CLK_I = ~CLK_I;

    // Edges since reset release; heartbeat with 4 bits is bit 3 of this.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) edge_cnt <= 32'd0;
        else        edge_cnt <= edge_cnt + 32'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Send one byte and check every cycle until busy drops; optionally fire
    // strobes that must be ignored (HI slot, LO padding, command wait).
    task automatic send_byte(input logic rs, input logic [7:0] b, input bit inject);
        logic [3:0] exp_d;
        logic       exp_e;
        int         kk;
        STB_I = 1'b1; i_rs = rs; i_lcd_data = b;
        @(posedge CLK_I); #1;
        STB_I = 1'b0; i_rs = 1'b0; i_lcd_data = 8'h00;
        for (int k = 0; k < 2 * NS + TB_DLY_CMD; k++) begin
            exp_d = (k < NS) ? b[7:4] : b[3:0];
            kk    = k % NS;
            exp_e = (k < 2 * NS) && (kk >= 1) && (kk <= 6);
            check_val("e", o_e, exp_e);
            check_val("data", o_lcd_data, exp_d);
            check_val("rs", o_rs, rs);
            check_val("busy", busy, 1'b1);
            check_val("alive", alive_led, edge_cnt[3]);
            STB_I = 1'b0;
            if (inject && k == 4) begin
                STB_I = 1'b1; i_rs = 1'b0; i_lcd_data = 8'h8E;
            end else if (inject && (k == NS + 10 || k == 2 * NS + 5)) begin
                STB_I = 1'b1; i_rs = 1'b0; i_lcd_data = 8'h5A;
            end else begin
                i_lcd_data = 8'h00;
            end
            @(posedge CLK_I); #1;
        end
        STB_I = 1'b0;
        check_val("busy_done", busy, 1'b0);
        check_val("hold_data", o_lcd_data, b[3:0]);
        check_val("hold_e", o_e, 1'b0);
    endtask

`ifdef H4_POWERON_INIT_EN
    logic [3:0] init_seq [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0,
                                  4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};

    // Record each nybble at its E rising edge until busy falls.
    task automatic check_init();
        int   n = 0;
        int   cyc = 0;
        logic prev_e = 1'b0;
        while (busy === 1'b1 && cyc < 2000) begin
            if (o_e === 1'b1 && prev_e === 1'b0) begin
                check_val("init_rs", o_rs, 1'b0);
                if (n < 14) check_val("init_nyb", o_lcd_data, init_seq[n]);
                n++;
            end
            prev_e = o_e;
            @(posedge CLK_I); #1;
            cyc++;
        end
        check_val("init_in_time", (cyc < 2000), 1'b1);
        check_val("init_count", n, 14);
    endtask
`endif

    initial begin
        RST_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        check_val("rst_busy", busy, RST_BUSY);
        check_val("rst_e", o_e, 1'b0);
        check_val("rst_rs", o_rs, 1'b0);
        check_val("rst_data", o_lcd_data, 4'h0);
        check_val("rst_alive", alive_led, 1'b0);
        RST_I = 1'b1;

`ifdef H4_POWERON_INIT_EN
        check_init();
`else
        repeat (2) @(posedge CLK_I);
        #1;
`endif
        send_byte(1'b1, 8'h6D, 1'b1);
        send_byte(1'b1, 8'hCB, 1'b0);
        send_byte(1'b0, 8'h3A, 1'b0);

        repeat (5) @(posedge CLK_I);
        #1;
        check_val("idle_busy", busy, 1'b0);
        check_val("idle_data", o_lcd_data, 4'hA);
        check_val("idle_rs", o_rs, 1'b0);
        check_val("idle_e", o_e, 1'b0);

        // Reset in the middle of an E pulse aborts immediately.
        STB_I = 1'b1; i_rs = 1'b1; i_lcd_data = 8'hF5;
        @(posedge CLK_I); #1;
        STB_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        check_val("mid_e_high", o_e, 1'b1);
        check_val("mid_data", o_lcd_data, 4'hF);
        RST_I = 1'b0;
        #1;
        check_val("abort_e", o_e, 1'b0);
        check_val("abort_data", o_lcd_data, 4'h0);
        check_val("abort_rs", o_rs, 1'b0);
        check_val("abort_busy", busy, RST_BUSY);
        check_val("abort_alive", alive_led, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
